multicycle_controller: RTL and testbench

//  Main control unit of the multicycle MIPS core. A Moore FSM sequences the shared

---
 rtl/mc_defs_pkg.sv | 62 ++++++
 rtl/multicycle_controller_alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 135 +++++++++++++
 tb/tb_multicycle_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_defs_pkg.sv
// rtl/mc_defs_pkg.sv - shared encodings for the multicycle MIPS control path
// Opcode/funct constants, state codes, aluop, alucontrol and mux-select encodings.
package mc_defs;

  localparam int OP_W    = 6;
  localparam int FUNCT_W = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - aluop/funct to ALU control decode
// Purely combinational; unknown funct codes fall back to add.
module alu_decoder
  import mc_defs::*;
#(
  parameter int FUNCT_W = 6
) (
  input  aluop_e             aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [2:0]         alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the multicycle MIPS datapath
// State register, next-state decode, per-state outputs and the pcen branch gate.
module multicycle_controller
  import mc_defs::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               pcen,
  output logic               irwrite,
  output logic               memwrite,
  output logic               iord,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal_op,
  output logic [3:0]         state_o
);

  state_e state_q, state_d;
  aluop_e aluop;
  logic   pcwrite, branch;
  logic   irwrite_s, memwrite_s, regwrite_s, illegal_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = SRCB_FOUR;
      end
      S_DECODE: begin
        alusrcb   = SRCB_IMM_SH2;
        illegal_s = ~is_legal_op(op);
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are held off for the whole time reset is high.
  assign pcen       = ~reset & (pcwrite | (branch & zero));
  assign irwrite    = ~reset & irwrite_s;
  assign memwrite   = ~reset & memwrite_s;
  assign regwrite   = ~reset & regwrite_s;
  assign illegal_op = ~reset & illegal_s;
  assign state_o    = state_q;

  alu_decoder #(.FUNCT_W(FUNCT_W)) u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
// Instruction-level model predicts state path and outputs each cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic [3:0] state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluctl;
    logic       illegal;
  } obs_t;

  obs_t exp_q[$];

  multicycle_controller #(.OP_W(6), .FUNCT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .iord       (iord),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // State path each opcode must walk, FETCH first.
  function automatic int path(input logic [5:0] o, input int k);
    int p[$];
    case (o)
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5};
      6'b000000: p = '{0, 1, 6, 7};
      6'b000100: p = '{0, 1, 8};
      6'b001000: p = '{0, 1, 9, 10};
      6'b000010: p = '{0, 1, 11};
      default:   p = '{0, 1};
    endcase
    return (k < p.size()) ? p[k] : -1;
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic obs_t model(input int st, input logic [5:0] o, input logic [5:0] f,
                                 input logic z);
    obs_t e;
    e        = '0;
    e.st     = st[3:0];
    e.aluctl = 3'b010;
    case (st)
      0:  begin e.irwrite = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'b01; end
      1:  begin
            e.alusrcb = 2'b11;
            e.illegal = !(o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
                          o == 6'b000100 || o == 6'b001000 || o == 6'b000010);
          end
      2, 9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      3:  e.iord = 1'b1;
      4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
      6:  begin e.alusrca = 1'b1; e.aluctl = rtype_alu(f); end
      7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      8:  begin e.alusrca = 1'b1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      10: e.regwrite = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{state_o, pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca,
            alusrcb, pcsrc, alucontrol, illegal_op};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle op=%b st_exp=%0d: actual=%h required=%h", op, e.st, a, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at the next FETCH.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int limit);
    int n;
    op    = o;
    funct = f;
    zero  = z;
    n     = 0;
    while (path(o, n) >= 0 && n < limit) begin
      exp_q.push_back(model(path(o, n), o, f, z));
      n++;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b000000;
    zero  = 1'b0;
    #2;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_irwrite", 32'(irwrite), 32'd0);
    chk("reset_pcen", 32'(pcen), 32'd0);
    chk("reset_alusrcb", 32'(alusrcb), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(6'b100011, 6'b101010, 1'b0, 99);
    run_instr(6'b000000, 6'b101010, 1'b0, 99);
    run_instr(6'b000000, 6'b100000, 1'b0, 99);
    run_instr(6'b000000, 6'b100010, 1'b1, 99);
    run_instr(6'b000000, 6'b100100, 1'b0, 99);
    run_instr(6'b000000, 6'b100101, 1'b0, 99);
    run_instr(6'b000000, 6'b111000, 1'b0, 99);
    run_instr(6'b000100, 6'b000000, 1'b1, 99);
    run_instr(6'b000100, 6'b000000, 1'b0, 99);
    run_instr(6'b101011, 6'b100010, 1'b1, 99);
    run_instr(6'b000010, 6'b000000, 1'b0, 99);
    run_instr(6'b001000, 6'b100010, 1'b0, 99);
    run_instr(6'b111111, 6'b100000, 1'b1, 99);
    run_instr(6'b000001, 6'b000000, 1'b0, 99);

    // sw interrupted by reset while in MEMWR
    run_instr(6'b101011, 6'b000000, 1'b0, 3);
    chk("memwr_state", 32'(state_o), 32'd5);
    chk("memwr_memwrite", 32'(memwrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_state", 32'(state_o), 32'd0);
    chk("rst_mid_memwrite", 32'(memwrite), 32'd0);
    chk("rst_mid_irwrite", 32'(irwrite), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_pcen", 32'(pcen), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_state", 32'(state_o), 32'd0);
    chk("post_rst_irwrite", 32'(irwrite), 32'd1);
    chk("post_rst_pcen", 32'(pcen), 32'd1);
    chk("post_rst_memwrite", 32'(memwrite), 32'd0);

    run_instr(6'b100011, 6'b000000, 1'b0, 99);
    run_instr(6'b000100, 6'b000000, 1'b1, 99);

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
